// File: rtl/axis_mem_pkg.sv
// Shared width helpers for the AXI-Stream memory responder.
// Beat layouts: request {ch_id, addr}, response {ch_id, data}, write {addr, data}.
package axis_mem_pkg;

  function automatic int ch_id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int req_width(input int ch_w, input int addr_w);
    return ch_w + addr_w;
  endfunction

  function automatic int rsp_width(input int ch_w, input int data_w);
    return ch_w + data_w;
  endfunction

  function automatic int wr_width(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

endpackage

// File: rtl/axis_resp_fifo.sv
// Two-entry response FIFO; slot0 is always the head and drives dout.
// Callers must not push into a full FIFO unless they pop in the same cycle.
module axis_resp_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] slot0_q, slot0_d;
  logic [WIDTH-1:0] slot1_q, slot1_d;
  logic [1:0]       count_q, count_d;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) slot0_d = din;
        else                 slot1_d = din;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        count_d = count_q - 2'd1;
      end
      // Simultaneous push and pop: occupancy holds, the tail shifts up.
      2'b11: begin
        if (count_q == 2'd2) begin
          slot0_d = slot1_q;
          slot1_d = din;
        end else begin
          slot0_d = din;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign dout  = slot0_q;
  assign count = count_q;
  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);

endmodule

// File: rtl/axis_mem_responder.sv
// Memory-side responder: word-addressed scratchpad with a streamed write port and a credited read port.
// Define AXIS_MEM_WR_FWD_EN for write-first same-address read/write; read-first otherwise.
module axis_mem_responder
  import axis_mem_pkg::*;
#(
  parameter int  ADDR_WIDTH = 2,
  parameter int  DATA_WIDTH = 64,
  parameter int  N_CHANNELS = 5,
  localparam int CH_ID_W    = ch_id_w(N_CHANNELS),
  localparam int REQ_W      = req_width(CH_ID_W, ADDR_WIDTH),
  localparam int RSP_W      = rsp_width(CH_ID_W, DATA_WIDTH),
  localparam int WR_W       = wr_width(ADDR_WIDTH, DATA_WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REQ_W-1:0] s_axis_req_tdata,
  input  logic             s_axis_req_tvalid,
  output logic             s_axis_req_tready,
  input  logic             s_axis_req_tlast,
  output logic [RSP_W-1:0] m_axis_pl_tdata,
  output logic             m_axis_pl_tvalid,
  input  logic             m_axis_pl_tready,
  output logic             m_axis_pl_tlast,
  input  logic [WR_W-1:0]  s_axis_wr_tdata,
  input  logic             s_axis_wr_tvalid,
  output logic             s_axis_wr_tready,
  input  logic             s_axis_wr_tlast
);

  typedef struct packed {
    logic [CH_ID_W-1:0]    ch_id;
    logic [DATA_WIDTH-1:0] data;
  } resp_beat_t;

  logic [CH_ID_W-1:0]    req_ch;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  req_fire, wr_fire, pop;
  logic [1:0]            fifo_count;
  logic                  fifo_empty, unused_fifo_full;
  logic                  unused_tlast;
  resp_beat_t            push_beat, head_beat;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_q, rd_d;
  logic [CH_ID_W-1:0]    rd_id_q, rd_id_d;
  logic                  inflight_q, inflight_d;

  assign {req_ch, req_addr} = s_axis_req_tdata;
  assign {wr_addr, wr_data} = s_axis_wr_tdata;
  assign unused_tlast       = s_axis_req_tlast ^ s_axis_wr_tlast;

  assign s_axis_wr_tready = !rst;
  assign wr_fire          = s_axis_wr_tvalid && s_axis_wr_tready;
  assign pop              = m_axis_pl_tvalid && m_axis_pl_tready;

  // A request needs a guaranteed FIFO slot for its response: slots held plus the one in flight.
  assign s_axis_req_tready = !rst && (((fifo_count + {1'b0, inflight_q}) < 2'd2) || pop);
  assign req_fire          = s_axis_req_tvalid && s_axis_req_tready;

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_addr] <= wr_data;
  end

  always_comb begin
    rd_d       = rd_q;
    rd_id_d    = rd_id_q;
    inflight_d = req_fire;
    if (req_fire) begin
      rd_id_d = req_ch;
`ifdef AXIS_MEM_WR_FWD_EN
      rd_d = (wr_fire && (wr_addr == req_addr)) ? wr_data : mem[req_addr];
`else
      rd_d = mem[req_addr];
`endif
    end
  end

  // Read data register stays reset-free so the array plus this stage maps onto block RAM.
  always_ff @(posedge clk) begin
    rd_q    <= rd_d;
    rd_id_q <= rd_id_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) inflight_q <= 1'b0;
    else     inflight_q <= inflight_d;
  end

  assign push_beat = '{ch_id: rd_id_q, data: rd_q};

  axis_resp_fifo #(
    .WIDTH (RSP_W)
  ) u_resp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .din   (push_beat),
    .pop   (pop),
    .dout  (head_beat),
    .count (fifo_count),
    .full  (unused_fifo_full),
    .empty (fifo_empty)
  );

  assign m_axis_pl_tdata  = head_beat;
  assign m_axis_pl_tvalid = !fifo_empty;
  assign m_axis_pl_tlast  = 1'b1;

endmodule

// File: tb/tb_axis_mem_responder.sv
// Directed and scoreboard-checked bench for axis_mem_responder (default parameters).
// Same-address expectations follow AXIS_MEM_WR_FWD_EN as compiled.
module tb_axis_mem_responder;

  localparam int CH_W = 3;
  localparam int AW   = 2;
  localparam int DW   = 64;
`ifdef AXIS_MEM_WR_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic [CH_W+AW-1:0]   req_tdata;
  logic                 req_tvalid, req_tready, req_tlast;
  logic [CH_W+DW-1:0]   pl_tdata;
  logic                 pl_tvalid, pl_tready, pl_tlast;
  logic [AW+DW-1:0]     wr_tdata;
  logic                 wr_tvalid, wr_tready, wr_tlast;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  axis_mem_responder dut (
    .clk               (clk),
    .rst               (rst),
    .s_axis_req_tdata  (req_tdata),
    .s_axis_req_tvalid (req_tvalid),
    .s_axis_req_tready (req_tready),
    .s_axis_req_tlast  (req_tlast),
    .m_axis_pl_tdata   (pl_tdata),
    .m_axis_pl_tvalid  (pl_tvalid),
    .m_axis_pl_tready  (pl_tready),
    .m_axis_pl_tlast   (pl_tlast),
    .s_axis_wr_tdata   (wr_tdata),
    .s_axis_wr_tvalid  (wr_tvalid),
    .s_axis_wr_tready  (wr_tready),
    .s_axis_wr_tlast   (wr_tlast)
  );

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    wr_tdata  = {a, d};
    wr_tvalid = 1'b1;
    @(negedge clk);
    wr_tvalid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_tvalid = 1'b0; req_tdata = '0; req_tlast = 1'b0;
    wr_tvalid = 1'b0; wr_tdata = '0; wr_tlast = 1'b1; pl_tready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_compared++; if (pl_tvalid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_tvalid: got %b expected 0", pl_tvalid); end
    n_compared++; if (pl_tdata !== '0) begin n_mismatched++; $display("[TB] FAIL reset_tdata: got %h expected 0", pl_tdata); end
    n_compared++; if (req_tready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_req_tready: got %b expected 0", req_tready); end
    n_compared++; if (wr_tready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_wr_tready: got %b expected 0", wr_tready); end
    n_compared++; if (pl_tlast !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_tlast: got %b expected 1", pl_tlast); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_compared++; if (req_tready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL post_reset_req_tready: got %b expected 1", req_tready); end
    n_compared++; if (wr_tready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL post_reset_wr_tready: got %b expected 1", wr_tready); end
  endtask

  task automatic test_basic;
    write_word(2'd2, 64'hDEAD_BEEF);
    pl_tready = 1'b1;
    @(negedge clk);
    req_tdata = {3'd3, 2'd2}; req_tvalid = 1'b1;
    #1;
    n_compared++; if (req_tready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL basic_req_tready: got %b expected 1", req_tready); end
    @(negedge clk);
    req_tvalid = 1'b0;
    #1;
    n_compared++; if (pl_tvalid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL basic_early_tvalid: got %b expected 0", pl_tvalid); end
    @(negedge clk);
    #1;
    n_compared++; if (pl_tvalid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL basic_tvalid: got %b expected 1", pl_tvalid); end
    n_compared++; if (pl_tdata !== {3'd3, 64'hDEAD_BEEF}) begin n_mismatched++; $display("[TB] FAIL basic_tdata: got %h expected %h", pl_tdata, {3'd3, 64'hDEAD_BEEF}); end
    n_compared++; if (pl_tlast !== 1'b1) begin n_mismatched++; $display("[TB] FAIL basic_tlast: got %b expected 1", pl_tlast); end
    @(negedge clk);
    #1;
    n_compared++; if (pl_tvalid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL basic_drained: got %b expected 0", pl_tvalid); end
  endtask

  task automatic test_streaming;
    logic [CH_W+DW-1:0] exp_beat;
    for (int i = 0; i < 4; i++) write_word(2'(i), 64'(10 + i));
    pl_tready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k < 4) begin req_tdata = {3'(k), 2'(k)}; req_tvalid = 1'b1; end
      else req_tvalid = 1'b0;
      #1;
      if (k < 4) begin
        n_compared++; if (req_tready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL stream_req_tready[%0d]: got %b expected 1", k, req_tready); end
      end
      if (k >= 2) begin
        exp_beat = {3'(k - 2), 64'(8 + k)};
        n_compared++; if (pl_tvalid !== 1'b1 || pl_tdata !== exp_beat) begin n_mismatched++; $display("[TB] FAIL stream_beat[%0d]: got v=%b %h expected v=1 %h", k - 2, pl_tvalid, pl_tdata, exp_beat); end
      end else begin
        n_compared++; if (pl_tvalid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL stream_early_tvalid[%0d]: got %b expected 0", k, pl_tvalid); end
      end
    end
    @(negedge clk);
    #1;
    n_compared++; if (pl_tvalid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL stream_drained: got %b expected 0", pl_tvalid); end
  endtask

  task automatic test_backpressure;
    int accepted = 0;
    pl_tready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      req_tdata = {3'(accepted), 2'(accepted)}; req_tvalid = 1'b1;
      #1;
      if (req_tready) accepted++;
    end
    n_compared++; if (accepted !== 2) begin n_mismatched++; $display("[TB] FAIL bp_accepted: got %0d expected 2", accepted); end
    n_compared++; if (req_tready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL bp_req_tready: got %b expected 0", req_tready); end
    n_compared++; if (pl_tvalid !== 1'b1 || pl_tdata !== {3'd0, 64'd10}) begin n_mismatched++; $display("[TB] FAIL bp_stalled_head: got v=%b %h expected v=1 %h", pl_tvalid, pl_tdata, {3'd0, 64'd10}); end
    @(negedge clk);
    req_tvalid = 1'b0; pl_tready = 1'b1;
    #1;
    n_compared++; if (pl_tvalid !== 1'b1 || pl_tdata !== {3'd0, 64'd10}) begin n_mismatched++; $display("[TB] FAIL bp_beat0: got v=%b %h expected v=1 %h", pl_tvalid, pl_tdata, {3'd0, 64'd10}); end
    @(negedge clk);
    #1;
    n_compared++; if (pl_tvalid !== 1'b1 || pl_tdata !== {3'd1, 64'd11}) begin n_mismatched++; $display("[TB] FAIL bp_beat1: got v=%b %h expected v=1 %h", pl_tvalid, pl_tdata, {3'd1, 64'd11}); end
    @(negedge clk);
    #1;
    n_compared++; if (pl_tvalid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL bp_no_duplicate: got %b expected 0", pl_tvalid); end
  endtask

  task automatic test_same_cycle;
    logic [CH_W+DW-1:0] exp_beat;
    exp_beat = FWD ? {3'd0, 64'd9} : {3'd0, 64'd5};
    write_word(2'd1, 64'd5);
    pl_tready = 1'b1;
    @(negedge clk);
    wr_tdata = {2'd1, 64'd9}; wr_tvalid = 1'b1;
    req_tdata = {3'd0, 2'd1}; req_tvalid = 1'b1;
    #1;
    n_compared++; if (req_tready !== 1'b1 || wr_tready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL same_both_ready: got req=%b wr=%b expected 1 1", req_tready, wr_tready); end
    @(negedge clk);
    wr_tvalid = 1'b0; req_tvalid = 1'b0;
    @(negedge clk);
    #1;
    n_compared++; if (pl_tvalid !== 1'b1 || pl_tdata !== exp_beat) begin n_mismatched++; $display("[TB] FAIL same_cycle_data: got v=%b %h expected v=1 %h", pl_tvalid, pl_tdata, exp_beat); end
    @(negedge clk);
    req_tdata = {3'd0, 2'd1}; req_tvalid = 1'b1;
    @(negedge clk);
    req_tvalid = 1'b0;
    @(negedge clk);
    #1;
    n_compared++; if (pl_tvalid !== 1'b1 || pl_tdata !== {3'd0, 64'd9}) begin n_mismatched++; $display("[TB] FAIL same_later_read: got v=%b %h expected v=1 %h", pl_tvalid, pl_tdata, {3'd0, 64'd9}); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    pl_tready = 1'b0;
    @(negedge clk);
    req_tdata = {3'd2, 2'd3}; req_tvalid = 1'b1;
    #1;
    n_compared++; if (req_tready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rmid_req0_ready: got %b expected 1", req_tready); end
    @(negedge clk);
    req_tdata = {3'd3, 2'd2};
    #1;
    n_compared++; if (req_tready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rmid_req1_ready: got %b expected 1", req_tready); end
    @(negedge clk);
    req_tvalid = 1'b0;
    @(negedge clk);
    #1;
    n_compared++; if (pl_tvalid !== 1'b1 || pl_tdata !== {3'd2, 64'd13}) begin n_mismatched++; $display("[TB] FAIL rmid_buffered: got v=%b %h expected v=1 %h", pl_tvalid, pl_tdata, {3'd2, 64'd13}); end
    rst = 1'b1;
    #1;
    n_compared++; if (pl_tvalid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rmid_async_tvalid: got %b expected 0", pl_tvalid); end
    n_compared++; if (req_tready !== 1'b0 || wr_tready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rmid_readies: got req=%b wr=%b expected 0 0", req_tready, wr_tready); end
    n_compared++; if (pl_tdata !== '0) begin n_mismatched++; $display("[TB] FAIL rmid_tdata: got %h expected 0", pl_tdata); end
    @(negedge clk);
    rst = 1'b0; pl_tready = 1'b1;
    #1;
    n_compared++; if (pl_tvalid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rmid_discarded: got %b expected 0", pl_tvalid); end
    @(negedge clk);
    req_tdata = {3'd1, 2'd0}; req_tvalid = 1'b1;
    @(negedge clk);
    req_tvalid = 1'b0;
    @(negedge clk);
    #1;
    n_compared++; if (pl_tvalid !== 1'b1 || pl_tdata !== {3'd1, 64'd10}) begin n_mismatched++; $display("[TB] FAIL rmid_new_read: got v=%b %h expected v=1 %h", pl_tvalid, pl_tdata, {3'd1, 64'd10}); end
    @(negedge clk);
    #1;
    n_compared++; if (pl_tvalid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rmid_single_beat: got %b expected 0", pl_tvalid); end
  endtask

  task automatic test_stress;
    logic [CH_W+DW-1:0] exp_q[$];
    logic [DW-1:0]      model_mem [4];
    logic [CH_W+DW-1:0] prev_data = '0;
    logic               prev_valid = 1'b0, prev_ready = 1'b0;
    logic [AW-1:0]      ra, wa;
    logic [DW-1:0]      wd, rd;
    for (int i = 0; i < 4; i++) begin
      model_mem[i] = {$urandom, $urandom};
      write_word(2'(i), model_mem[i]);
    end
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (prev_valid && !prev_ready) begin
        n_compared++; if (pl_tvalid !== 1'b1 || pl_tdata !== prev_data) begin n_mismatched++; $display("[TB] FAIL stress_stable[%0d]: got v=%b %h expected v=1 %h", c, pl_tvalid, pl_tdata, prev_data); end
      end
      ra = 2'($urandom); wa = 2'($urandom); wd = {$urandom, $urandom};
      req_tdata  = {3'($urandom_range(0, 4)), ra};
      req_tvalid = 1'($urandom_range(0, 1));
      wr_tdata   = {wa, wd};
      wr_tvalid  = ($urandom_range(0, 3) == 0);
      pl_tready  = ($urandom_range(0, 3) != 0);
      #1;
      if (req_tvalid && req_tready) begin
        rd = (FWD && wr_tvalid && wa == ra) ? wd : model_mem[ra];
        exp_q.push_back({req_tdata[CH_W+AW-1:AW], rd});
      end
      if (wr_tvalid && wr_tready) model_mem[wa] = wd;
      if (pl_tvalid && pl_tready) begin
        n_compared++;
        if (exp_q.size() == 0) begin n_mismatched++; $display("[TB] FAIL stress_spurious[%0d]: got %h expected no beat", c, pl_tdata); end
        else begin
          if (pl_tdata !== exp_q[0]) begin n_mismatched++; $display("[TB] FAIL stress_beat[%0d]: got %h expected %h", c, pl_tdata, exp_q[0]); end
          void'(exp_q.pop_front());
        end
      end
      prev_valid = pl_tvalid; prev_ready = pl_tready; prev_data = pl_tdata;
    end
    @(negedge clk);
    req_tvalid = 1'b0; wr_tvalid = 1'b0; pl_tready = 1'b1;
    for (int d = 0; d < 6; d++) begin
      #1;
      if (pl_tvalid) begin
        n_compared++;
        if (exp_q.size() == 0) begin n_mismatched++; $display("[TB] FAIL drain_spurious: got %h expected no beat", pl_tdata); end
        else begin
          if (pl_tdata !== exp_q[0]) begin n_mismatched++; $display("[TB] FAIL drain_beat: got %h expected %h", pl_tdata, exp_q[0]); end
          void'(exp_q.pop_front());
        end
      end
      @(negedge clk);
    end
    #1;
    n_compared++; if (exp_q.size() != 0 || pl_tvalid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL stress_lost: got %0d pending v=%b expected 0 pending v=0", exp_q.size(), pl_tvalid); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_streaming;
    test_backpressure;
    test_same_cycle;
    test_reset_mid;
    test_stress;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
